// File: rtl/pg_retention_ctrl_pkg.sv
// Shared definitions for the deep-sleep state-retention responder.
package pg_retention_ctrl_pkg;

  localparam int RET_NUM_WORDS = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SAVE_RD    = 3'd1,
    ST_SAVE_DRAIN = 3'd2,
    ST_DONE_S     = 3'd3,
    ST_RESTORE_WR = 3'd4,
    ST_DONE_R     = 3'd5
  } state_e;

endpackage

// File: rtl/pg_retention_ctrl_ret_mem.sv
// Always-on retention array: one synchronous write port, one combinational read port.
module ret_mem #(
  parameter int NUM_WORDS = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Not reset: the controller's ret_valid flag qualifies the contents.
  logic [DATA_W-1:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pg_retention_ctrl.sv
// Saves the power-gated domain's state words into an always-on array on a save
// request and writes them back on a restore request.
module pg_retention_ctrl
  import pg_retention_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = RET_NUM_WORDS,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              save,
  input  logic              restore,
  output logic              st_rd_en,
  output logic [ADDR_W-1:0] st_rd_addr,
  input  logic [DATA_W-1:0] st_rd_data,
  output logic              st_wr_en,
  output logic [ADDR_W-1:0] st_wr_addr,
  output logic [DATA_W-1:0] st_wr_data,
  output logic              ret_valid,
  output logic              busy,
  output logic              save_done,
  output logic              restore_done,
  output logic              ret_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ret_err_q, ret_err_d;
  logic              save_q, restore_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              save_rise, save_fall, restore_rise;

  assign save_rise    = save & ~save_q;
  assign save_fall    = ~save & save_q;
  assign restore_rise = restore & ~restore_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ret_valid_d = ret_valid_q;
    ret_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Save takes priority when both requests rise together.
        if (save_rise) begin
          ret_valid_d = 1'b0;
          state_d     = ST_SAVE_RD;
        end else if (restore_rise) begin
          if (ret_valid_q) begin
            state_d = ST_RESTORE_WR;
          end else begin
            ret_err_d = 1'b1;
          end
        end
      end
      ST_SAVE_RD: begin
        if (save_fall) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_SAVE_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAVE_DRAIN: begin
        if (save_fall) begin
          state_d = ST_IDLE;
        end else begin
          state_d     = ST_DONE_S;
          ret_valid_d = 1'b1;
        end
      end
      ST_DONE_S: state_d = ST_IDLE;
      ST_RESTORE_WR: begin
        if (cnt_q == LAST) begin
          state_d = ST_DONE_R;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE_R: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    st_rd_en     = 1'b0;
    st_rd_addr   = '0;
    st_wr_en     = 1'b0;
    st_wr_addr   = '0;
    st_wr_data   = '0;
    save_done    = 1'b0;
    restore_done = 1'b0;
    busy         = (state_q != ST_IDLE);
    ret_valid    = ret_valid_q;
    ret_err      = ret_err_q;
    case (state_q)
      ST_SAVE_RD: begin
        st_rd_en   = 1'b1;
        st_rd_addr = cnt_q;
      end
      ST_RESTORE_WR: begin
        st_wr_en   = 1'b1;
        st_wr_addr = cnt_q;
        st_wr_data = mem_rdata;
      end
      ST_DONE_S: save_done    = 1'b1;
      ST_DONE_R: restore_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ret_valid_q <= 1'b0;
      ret_err_q   <= 1'b0;
      save_q      <= 1'b0;
      restore_q   <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ret_valid_q <= ret_valid_d;
      ret_err_q   <= ret_err_d;
      save_q      <= save;
      restore_q   <= restore;
      rd_en_q     <= st_rd_en;
    end
  end

  // Read data returns one cycle after the strobe, so the address is delayed to match.
  always_ff @(posedge cpu_clk) begin
    addr_q <= st_rd_addr;
  end

  ret_mem #(
    .NUM_WORDS (NUM_WORDS),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W)
  ) u_ret_mem (
    .clk   (cpu_clk),
    .we    (rd_en_q),
    .waddr (addr_q),
    .wdata (st_rd_data),
    .raddr (cnt_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_pg_retention_ctrl.sv
// Bench for pg_retention_ctrl: vector table, directed save/restore sequences,
// randomized requests against a cycle-offset reference model, and a 256-word run.
module tb_pg_retention_ctrl;

  localparam int N4   = 4;
  localparam int NB   = 256;
  localparam int DW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-word instance
  logic          rst4 = 1'b1, save4 = 1'b0, restore4 = 1'b0;
  logic          rd_en4, wr_en4, valid4, busy4, sdone4, rdone4, err4;
  logic [1:0]    rd_addr4, wr_addr4;
  logic [DW-1:0] rd_data4 = '0, wr_data4;
  logic [DW-1:0] dom4 [N4];

  // 256-word instance
  logic          rstb = 1'b1, saveb = 1'b0, restoreb = 1'b0;
  logic          rd_enb, wr_enb, validb, busyb, sdoneb, rdoneb, errb;
  logic [7:0]    rd_addrb, wr_addrb;
  logic [DW-1:0] rd_datab = '0, wr_datab;
  logic [DW-1:0] domb [NB];

  pg_retention_ctrl #(.NUM_WORDS(N4), .DATA_W(DW)) dut4 (
    .cpu_clk(clk), .cpu_rst(rst4), .save(save4), .restore(restore4),
    .st_rd_en(rd_en4), .st_rd_addr(rd_addr4), .st_rd_data(rd_data4),
    .st_wr_en(wr_en4), .st_wr_addr(wr_addr4), .st_wr_data(wr_data4),
    .ret_valid(valid4), .busy(busy4), .save_done(sdone4),
    .restore_done(rdone4), .ret_err(err4)
  );

  pg_retention_ctrl #(.NUM_WORDS(NB), .DATA_W(DW)) dutb (
    .cpu_clk(clk), .cpu_rst(rstb), .save(saveb), .restore(restoreb),
    .st_rd_en(rd_enb), .st_rd_addr(rd_addrb), .st_rd_data(rd_datab),
    .st_wr_en(wr_enb), .st_wr_addr(wr_addrb), .st_wr_data(wr_datab),
    .ret_valid(validb), .busy(busyb), .save_done(sdoneb),
    .restore_done(rdoneb), .ret_err(errb)
  );

  // Domain state ports: read data one cycle after the strobe
  always @(posedge clk) begin
    rd_data4 <= rd_en4 ? dom4[rd_addr4] : '0;
    rd_datab <= rd_enb ? domb[rd_addrb] : '0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step4(input logic r, input logic s, input logic q);
    @(negedge clk);
    rst4 = r; save4 = s; restore4 = q;
    @(posedge clk);
    #1;
  endtask

  task automatic stepb(input logic r, input logic s, input logic q);
    @(negedge clk);
    rstb = r; saveb = s; restoreb = q;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] flags4();
    return {busy4, rd_en4, wr_en4, sdone4, rdone4, err4, valid4};
  endfunction

  // {rst, save, restore} applied at an edge; expected flags just after it:
  // {busy, st_rd_en, st_wr_en, save_done, restore_done, ret_err, ret_valid}
  typedef struct packed {
    logic       rst;
    logic       sv;
    logic       rs;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic q, input logic [6:0] e);
    vec_t v;
    v.rst = r; v.sv = s; v.rs = q; v.exp = e;
    tbl.push_back(v);
  endtask

  // Reference model state (cycle offsets since the accepted request)
  int         m_mode;   // 0 idle, 1 save, 2 restore
  int         m_k;
  logic       m_valid, m_err, m_ps, m_pq;
  logic [DW-1:0] m_snap [N4];

  initial begin
    logic s, q, r;
    logic [63:0] exp_v;
    int bad, nacc, off, exp_addr;

    // ---------------- vector table (N=4) ----------------
    add(1, 0, 0, 7'b0000000);  // reset state
    add(0, 0, 1, 7'b0000010);  // restore with no snapshot -> ret_err
    add(0, 0, 1, 7'b0000000);
    add(0, 0, 0, 7'b0000000);
    add(0, 1, 1, 7'b1100000);  // both rise: save wins
    add(0, 1, 1, 7'b1100000);
    add(0, 1, 1, 7'b1100000);
    add(0, 1, 1, 7'b1100000);
    add(0, 1, 1, 7'b1000000);  // drain
    add(0, 1, 1, 7'b1001001);  // save_done + ret_valid
    add(0, 1, 1, 7'b0000001);  // restore edge was lost
    add(0, 0, 0, 7'b0000001);
    add(0, 0, 1, 7'b1010001);  // restore running
    add(0, 0, 1, 7'b1010001);
    add(1, 0, 1, 7'b0000000);  // reset mid-restore
    add(0, 0, 0, 7'b0000000);
    add(0, 0, 1, 7'b0000010);  // snapshot gone
    add(0, 1, 0, 7'b1100000);
    add(0, 1, 0, 7'b1100000);
    add(0, 0, 0, 7'b0000000);  // save aborted
    add(0, 0, 1, 7'b0000010);
    add(0, 0, 0, 7'b0000000);
    for (int i = 0; i < tbl.size(); i++) begin
      step4(tbl[i].rst, tbl[i].sv, tbl[i].rs);
      check($sformatf("tbl_row%0d", i), 64'(flags4()), 64'(tbl[i].exp));
    end

    // ---------------- directed save / restore (N=4) ----------------
    step4(1, 0, 0);
    step4(0, 0, 0);
    for (int j = 0; j < N4; j++) dom4[j] = 32'hA0 + j;
    step4(0, 1, 0);
    for (int j = 0; j < N4; j++) begin
      check($sformatf("save_rd%0d", j), 64'({rd_en4, wr_en4, rd_addr4}), 64'({1'b1, 1'b0, 2'(j)}));
      step4(0, 1, 0);
    end
    check("save_drain", 64'(flags4()), 64'(7'b1000000));
    step4(0, 1, 0);
    check("save_done", 64'(flags4()), 64'(7'b1001001));
    step4(0, 0, 0);
    check("save_idle", 64'(flags4()), 64'(7'b0000001));
    step4(0, 0, 1);
    for (int j = 0; j < N4; j++) begin
      check($sformatf("rest_wr%0d", j), 64'({rd_en4, wr_en4, wr_addr4, wr_data4}),
            64'({1'b0, 1'b1, 2'(j), 32'hA0 + 32'(j)}));
      step4(0, 0, 1);
    end
    check("rest_done", 64'(flags4()), 64'(7'b1000101));
    step4(0, 0, 0);
    check("rest_idle", 64'(flags4()), 64'(7'b0000001));

    // ---------------- randomized vs reference model (N=4) ----------------
    step4(1, 0, 0);
    m_mode = 0; m_k = 0; m_valid = 0; m_err = 0; m_ps = 0; m_pq = 0;
    s = 0; q = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_mode == 0) begin
        for (int j = 0; j < N4; j++) dom4[j] = $urandom;
      end
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) s = ~s;
      if ($urandom_range(0, 5) == 0) q = ~q;
      step4(r, s, q);

      m_err = 0;
      if (r) begin
        m_mode = 0; m_k = 0; m_valid = 0;
      end else begin
        case (m_mode)
          0: begin
            if (s && !m_ps) begin
              m_mode = 1; m_k = 1; m_valid = 0;
            end else if (q && !m_pq) begin
              if (m_valid) begin m_mode = 2; m_k = 1; end
              else m_err = 1;
            end
          end
          1: begin
            if (m_k == N4 + 2) m_mode = 0;
            else if (!s && m_ps) m_mode = 0;
            else begin
              m_k++;
              if (m_k == N4 + 2) begin
                m_valid = 1;
                for (int j = 0; j < N4; j++) m_snap[j] = dom4[j];
              end
            end
          end
          default: begin
            if (m_k == N4 + 1) m_mode = 0;
            else m_k++;
          end
        endcase
      end
      m_ps = r ? 1'b0 : s;
      m_pq = r ? 1'b0 : q;

      exp_v = '0;
      exp_v[42:36] = {m_mode != 0,
                      m_mode == 1 && m_k <= N4,
                      m_mode == 2 && m_k <= N4,
                      m_mode == 1 && m_k == N4 + 2,
                      m_mode == 2 && m_k == N4 + 1,
                      m_err, m_valid};
      if (m_mode == 1 && m_k <= N4) exp_v[35:34] = 2'(m_k - 1);
      if (m_mode == 2 && m_k <= N4) begin
        exp_v[33:32] = 2'(m_k - 1);
        exp_v[31:0]  = m_snap[m_k - 1];
      end
      check($sformatf("rand_cyc%0d", c),
            {21'd0, flags4(), rd_addr4, wr_addr4, wr_data4}, exp_v);
    end

    // ---------------- 256-word save then restore ----------------
    for (int j = 0; j < NB; j++) domb[j] = 32'h5A00_0000 + 32'(j) * 32'd7;
    stepb(1, 0, 0);
    stepb(0, 0, 0);
    stepb(0, 1, 0);
    bad = 0; nacc = 0; off = -1; exp_addr = 0;
    for (int o = 1; o <= 300 && off < 0; o++) begin
      if (rd_enb) begin
        if (rd_addrb !== 8'(exp_addr)) bad++;
        exp_addr++;
        nacc++;
      end
      if (sdoneb) off = o;
      else stepb(0, 1, 0);
    end
    check("big_reads", 64'(nacc), 64'(NB));
    check("big_rd_addr_bad", 64'(bad), 64'(0));
    check("big_save_done_off", 64'(off), 64'(NB + 2));
    check("big_valid", 64'(validb), 64'(1));
    stepb(0, 0, 0);
    stepb(0, 0, 1);
    bad = 0; nacc = 0; off = -1;
    for (int o = 1; o <= 300 && off < 0; o++) begin
      if (wr_enb) begin
        if (wr_addrb !== 8'(nacc) || wr_datab !== 32'h5A00_0000 + 32'(nacc) * 32'd7) bad++;
        nacc++;
      end
      if (rdoneb) off = o;
      else stepb(0, 0, 1);
    end
    check("big_writes", 64'(nacc), 64'(NB));
    check("big_wr_bad", 64'(bad), 64'(0));
    check("big_restore_done_off", 64'(off), 64'(NB + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
